scan_seq_3_6: RTL and testbench

SCAN_SEQ_3_6 -- requirements
Module: scan_seq_3_6

---
 rtl/scan_seq_3_6.sv | 200 ++++++++++++++++++++
 tb/tb_scan_seq_3_6.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/scan_seq_3_6.sv
// -----------------------------------------------------------------------------
// scan_seq_3_6
// Generates the 3-bit select code for a downstream 3-to-6 decoder. The code
// advances one step every DIV clock cycles. It runs either as a continuous
// scan while en is held, or as a single up/down sweep after a start pulse.
//
// Parameters
//   DIV       clock cycles per code step (1..255)
//   LAST      highest code emitted (1..7)
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        level, continuous scan request (has priority over start)
//   start     single-cycle pulse, request one full sweep
//   dir       0 = count up, 1 = count down, sampled at each step
//   load      single-cycle pulse, force the code to load_val
//   load_val  code to load (values above LAST are rejected)
//   a         registered decoder select code
//   valid     registered, high while scanning or sweeping
//   wrap      registered pulse on each wrap-around step
//   done      registered pulse when a sweep completes
//   err       registered pulse on a rejected load
// -----------------------------------------------------------------------------
module scan_seq_3_6 #(
    parameter int unsigned DIV  = 4,
    parameter int unsigned LAST = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] a,
    output logic       valid,
    output logic       wrap,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam logic [2:0] LAST_C = 3'(LAST);
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t     state_r;
    state_t     state_s;
    logic [2:0] a_r;
    logic [2:0] a_s;
    logic [7:0] pcnt_r;
    logic [7:0] pcnt_s;
    logic       valid_r;
    logic       wrap_r;
    logic       wrap_s;
    logic       done_r;
    logic       done_s;
    logic       err_r;
    logic       err_s;
    logic       step_s;
    logic       at_end_s;
    logic       load_ok_s;

    // Step strobe, end-of-range detect for the current direction, load legality.
    always_comb begin
        step_s    = (state_r != ST_IDLE) && (pcnt_r == DIV_M1);
        at_end_s  = dir ? (a_r == 3'd0) : (a_r == LAST_C);
        load_ok_s = (load_val <= LAST_C);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. A load (legal or not) leaves the state untouched.
    always_comb begin
        state_s = state_r;
        if (load) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_s = ST_SCAN;
                    end else if (start) begin
                        state_s = ST_SWEEP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (!en) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_SCAN;
                    end
                end
                ST_SWEEP: begin
                    // en hands the sweep over to a continuous scan.
                    if (en) begin
                        state_s = ST_SCAN;
                    end else if (step_s && at_end_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_SWEEP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Code, prescaler and pulse outputs for the coming edge.
    always_comb begin
        a_s    = a_r;
        pcnt_s = pcnt_r;
        wrap_s = 1'b0;
        done_s = 1'b0;
        err_s  = 1'b0;
        if (load) begin
            if (load_ok_s) begin
                a_s    = load_val;
                pcnt_s = 8'd0;
            end else begin
                err_s  = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pcnt_s = 8'd0;
                    // Sweep entry jumps to the starting end of the range.
                    if (!en && start) begin
                        a_s = dir ? LAST_C : 3'd0;
                    end else begin
                        a_s = a_r;
                    end
                end
                ST_SCAN, ST_SWEEP: begin
                    if ((state_r == ST_SCAN) && !en) begin
                        pcnt_s = 8'd0;
                    end else if (!step_s) begin
                        pcnt_s = pcnt_r + 8'd1;
                    end else begin
                        pcnt_s = 8'd0;
                        if (!at_end_s) begin
                            a_s = dir ? (a_r - 3'd1) : (a_r + 3'd1);
                        end else if ((state_r == ST_SWEEP) && !en) begin
                            // Sweep ends on the step that would have wrapped.
                            done_s = 1'b1;
                        end else begin
                            a_s    = dir ? LAST_C : 3'd0;
                            wrap_s = 1'b1;
                        end
                    end
                end
                default: begin
                    a_s    = 3'd0;
                    pcnt_s = 8'd0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= 3'd0;
            pcnt_r  <= 8'd0;
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            a_r     <= a_s;
            pcnt_r  <= pcnt_s;
            valid_r <= (state_s != ST_IDLE);
            wrap_r  <= wrap_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign a     = a_r;
    assign valid = valid_r;
    assign wrap  = wrap_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: tb/tb_scan_seq_3_6.sv
module tb_scan_seq_3_6;

    logic       clk = 1'b0;
    logic       rst, en, start, dir, load;
    logic [2:0] load_val;
    logic [2:0] a4, a1;
    logic       valid4, wrap4, done4, err4;
    logic       valid1, wrap1, done1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_seq_3_6 #(.DIV(4), .LAST(5)) u_div4 (
        .clk(clk), .rst(rst), .en(en), .start(start), .dir(dir),
        .load(load), .load_val(load_val),
        .a(a4), .valid(valid4), .wrap(wrap4), .done(done4), .err(err4)
    );

    scan_seq_3_6 #(.DIV(1), .LAST(5)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .dir(dir),
        .load(load), .load_val(load_val),
        .a(a1), .valid(valid1), .wrap(wrap1), .done(done1), .err(err1)
    );

    typedef struct {
        logic       rst, en, start, dir, load;
        logic [2:0] lv;
        logic [2:0] ea;
        logic       ev, ew, ed, ee;
    } vec_t;

    typedef struct {
        bit         div1;
        logic [2:0] a;
        logic       v, w, d, e;
        string      nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[23];

    function automatic vec_t mk(logic r, logic e, logic s, logic d, logic l,
                                logic [2:0] lv, logic [2:0] ea,
                                logic ev, logic ew, logic ed, logic ee);
        vec_t x;
        x.rst = r; x.en = e; x.start = s; x.dir = d; x.load = l; x.lv = lv;
        x.ea = ea; x.ev = ev; x.ew = ew; x.ed = ed; x.ee = ee;
        return x;
    endfunction

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic apply(input vec_t x, input bit div1, input string nm);
        exp_t ex;
        exp_t got;
        logic [2:0] aa;
        logic vv, ww, dd, ee;
        rst = x.rst; en = x.en; start = x.start; dir = x.dir;
        load = x.load; load_val = x.lv;
        ex.div1 = div1; ex.a = x.ea; ex.v = x.ev; ex.w = x.ew; ex.d = x.ed;
        ex.e = x.ee; ex.nm = nm;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (got.div1) begin
            aa = a1; vv = valid1; ww = wrap1; dd = done1; ee = err1;
        end else begin
            aa = a4; vv = valid4; ww = wrap4; dd = done4; ee = err4;
        end
        checks++;
        if (aa !== got.a || vv !== got.v || ww !== got.w || dd !== got.d || ee !== got.e) begin
            errors++;
            $display("FAIL %s: got a=%0d valid=%b wrap=%b done=%b err=%b, expected a=%0d valid=%b wrap=%b done=%b err=%b",
                     got.nm, aa, vv, ww, dd, ee, got.a, got.v, got.w, got.d, got.e);
        end
    endtask

    // Shorthand for the hand-written DIV=4 sequences.
    task automatic cyc(input logic r, input logic e, input logic s, input logic d,
                       input logic l, input logic [2:0] lv, input logic [2:0] ea,
                       input logic ev, input logic ew, input logic ed, input logic ee,
                       input string nm);
        apply(mk(r, e, s, d, l, lv, ea, ev, ew, ed, ee), 1'b0, nm);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; dir = 1'b0; load = 1'b0; load_val = 3'd0;

        // DIV=1 vectors: rst en start dir load lv | a valid wrap done err
        tbl[0]  = mk(1,0,0,0,0,3'd0, 3'd0,0,0,0,0); // reset state
        tbl[1]  = mk(0,0,1,1,0,3'd0, 3'd5,1,0,0,0); // sweep down entry
        tbl[2]  = mk(0,0,0,1,0,3'd0, 3'd4,1,0,0,0);
        tbl[3]  = mk(0,0,0,1,0,3'd0, 3'd3,1,0,0,0);
        tbl[4]  = mk(0,0,0,1,0,3'd0, 3'd2,1,0,0,0);
        tbl[5]  = mk(0,0,0,1,0,3'd0, 3'd1,1,0,0,0);
        tbl[6]  = mk(0,0,0,1,0,3'd0, 3'd0,1,0,0,0);
        tbl[7]  = mk(0,0,0,1,0,3'd0, 3'd0,0,0,1,0); // done, no wrap
        tbl[8]  = mk(0,0,0,1,0,3'd0, 3'd0,0,0,0,0);
        tbl[9]  = mk(0,0,0,0,1,3'd6, 3'd0,0,0,0,1); // illegal load
        tbl[10] = mk(0,0,0,0,1,3'd3, 3'd3,0,0,0,0); // legal load in idle
        tbl[11] = mk(0,0,0,0,0,3'd0, 3'd3,0,0,0,0);
        tbl[12] = mk(0,1,0,0,0,3'd0, 3'd3,1,0,0,0); // scan entry holds a
        tbl[13] = mk(0,1,0,0,0,3'd0, 3'd4,1,0,0,0);
        tbl[14] = mk(0,1,0,0,0,3'd0, 3'd5,1,0,0,0);
        tbl[15] = mk(0,1,0,0,0,3'd0, 3'd0,1,1,0,0); // wrap up
        tbl[16] = mk(0,1,0,1,0,3'd0, 3'd5,1,1,0,0); // wrap down after dir change
        tbl[17] = mk(0,1,0,1,0,3'd0, 3'd4,1,0,0,0);
        tbl[18] = mk(0,0,0,1,0,3'd0, 3'd4,0,0,0,0); // scan end, a holds
        tbl[19] = mk(0,0,1,0,0,3'd0, 3'd0,1,0,0,0); // sweep up entry
        tbl[20] = mk(0,0,1,0,0,3'd0, 3'd1,1,0,0,0); // start ignored in sweep
        tbl[21] = mk(0,1,0,0,0,3'd0, 3'd2,1,0,0,0); // en hands over to scan
        tbl[22] = mk(0,0,0,0,0,3'd0, 3'd2,0,0,0,0);

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i], 1'b1, $sformatf("div1_vec%0d", i));
        end

        // DIV=4 continuous scan up: step every 4 cycles, wrap at 5->0.
        cyc(1,0,0,0,0,3'd0, 3'd0,0,0,0,0, "d4_reset");
        for (int i = 0; i < 36; i++) begin
            cyc(0,1,0,0,0,3'd0, 3'((i / 4) % 6),1,(i == 24),0,0, $sformatf("d4_scan_%0d", i));
        end
        // Load 4 on the step edge from a=2: prescaler restarts.
        cyc(0,1,0,0,1,3'd4, 3'd4,1,0,0,0, "d4_load_step");
        for (int i = 0; i < 3; i++) begin
            cyc(0,1,0,0,0,3'd0, 3'd4,1,0,0,0, $sformatf("d4_after_load_%0d", i));
        end
        cyc(0,1,0,0,0,3'd0, 3'd5,1,0,0,0, "d4_step_to5");
        cyc(0,0,0,0,0,3'd0, 3'd5,0,0,0,0, "d4_scan_end");
        cyc(0,0,0,0,1,3'd7, 3'd5,0,0,0,1, "d4_err7");
        cyc(0,0,0,0,0,3'd0, 3'd5,0,0,0,0, "d4_err_clear");

        // Sweep aborted by reset at a=3.
        cyc(0,0,1,0,0,3'd0, 3'd0,1,0,0,0, "d4_sweep_entry");
        for (int i = 1; i < 14; i++) begin
            cyc(0,0,0,0,0,3'd0, 3'(i / 4),1,0,0,0, $sformatf("d4_sweep_%0d", i));
        end
        cyc(1,0,0,0,0,3'd0, 3'd0,0,0,0,0, "d4_rst_mid_sweep");
        cyc(0,0,0,0,0,3'd0, 3'd0,0,0,0,0, "d4_no_done_after_rst");

        // Full sweep up lasts (LAST+1)*DIV = 24 cycles from entry.
        cyc(0,0,1,0,0,3'd0, 3'd0,1,0,0,0, "d4_full_entry");
        for (int i = 1; i < 24; i++) begin
            cyc(0,0,0,0,0,3'd0, 3'(i / 4),1,0,0,0, $sformatf("d4_full_%0d", i));
        end
        cyc(0,0,0,0,0,3'd0, 3'd5,0,0,1,0, "d4_full_done");
        cyc(0,0,0,0,0,3'd0, 3'd5,0,0,0,0, "d4_done_single");

        // en and start together: scan wins, no done at scan end.
        cyc(0,1,1,0,0,3'd0, 3'd5,1,0,0,0, "d4_en_start");
        cyc(0,1,0,0,0,3'd0, 3'd5,1,0,0,0, "d4_en_hold1");
        cyc(0,1,0,0,0,3'd0, 3'd5,1,0,0,0, "d4_en_hold2");
        cyc(0,0,0,0,0,3'd0, 3'd5,0,0,0,0, "d4_en_drop");
        cyc(0,0,0,0,0,3'd0, 3'd5,0,0,0,0, "d4_no_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
